fetch_unit: RTL

//  Instruction fetch stage for the 8-bit RISC core. Owns the program counter and drives the
//  256x16 instruction memory, which has a 1-cycle registered read. Captures each returned word

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_buffer.sv | 62 ++++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 16;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, execute redirect and decode handshake.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_read_en;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               dec_ready;
    logic               dec_valid;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic [2:0]         dec_op;
    logic               halted;

    modport master (
        output imem_addr, imem_read_en, dec_valid, dec_instr, dec_pc, dec_op, halted,
        input  imem_instr, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_addr, imem_read_en, dec_valid, dec_instr, dec_pc, dec_op, halted,
        output imem_instr, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO holding captured {instruction, pc} pairs; head is presented to decode.
module fetch_buffer #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    assign push_ok_s = push && (count_r != CNT_W'(DEPTH));
    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (!push_ok_s && pop_ok_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, issue control, redirect flush and decode buffer.
// Optional HALT detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = FETCH_ADDR_W,
    parameter int                 INSTR_W   = FETCH_INSTR_W,
    parameter int                 BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC  = {ADDR_W{1'b0}}
) (
    input  logic      clk,
    input  logic      rst,
    fetch_if.master   fif
);
    localparam int BUF_W = INSTR_W + ADDR_W;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t       state_r;
    fetch_state_t       state_nxt_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  inflight_pc_r;
    logic               inflight_r;
    logic               issue_s;
    logic               push_s;
    logic               pop_s;
    logic [CNT_W:0]     occupancy_s;
    logic [CNT_W-1:0]   count_s;
    logic [BUF_W-1:0]   head_s;
    logic [INSTR_W-1:0] head_instr_s;

    assign pop_s        = (count_s != {CNT_W{1'b0}}) && fif.dec_ready;
    assign head_instr_s = head_s[BUF_W-1 -: INSTR_W];

    assign fif.imem_addr    = pc_r;
    assign fif.imem_read_en = issue_s;
    assign fif.dec_valid    = (count_s != {CNT_W{1'b0}});
    assign fif.dec_instr    = head_instr_s;
    assign fif.dec_pc       = head_s[ADDR_W-1:0];
    assign fif.dec_op       = head_instr_s[INSTR_W-1 -: 3];

    // Issue only when the word will have a free slot once it returns.
    always_comb begin
        occupancy_s = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
        if (rst) begin
            issue_s = 1'b0;
        end else if ((state_r == ST_RUN) && !fif.redirect_valid &&
                     (occupancy_s < (CNT_W + 1)'(BUF_DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // A returning word is dropped when a redirect or halt has made it wrong-path.
    always_comb begin
        if (inflight_r && !rst && !fif.redirect_valid && (state_r == ST_RUN)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Program counter and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
        end else begin
            if (fif.redirect_valid) begin
                pc_r <= fif.redirect_pc;
            end else if (issue_s) begin
                pc_r <= pc_r + ADDR_W'(1);
            end
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end
        end
    end

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch state transitions; HALT is entered only with detection compiled in.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
`ifdef FETCH_HALT_DETECT_EN
                if (push_s && (fif.imem_instr[INSTR_W-1 -: 3] == OP_HALT)) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
`else
                state_nxt_s = ST_RUN;
`endif
            end
            ST_HALT: begin
                if (fif.redirect_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

`ifdef FETCH_HALT_DETECT_EN
    assign fif.halted = (state_r == ST_HALT);
`else
    assign fif.halted = 1'b0;
`endif

    fetch_buffer #(
        .WIDTH (BUF_W),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({fif.imem_instr, inflight_pc_r}),
        .pop       (pop_s),
        .flush     (fif.redirect_valid),
        .count     (count_s),
        .head      (head_s)
    );
endmodule
